// File: rtl/step_ctrl.sv
// Step clock-enable generator: debounced single-step key or divided free-run, with halt on Done.
// Optional StepCount output is enabled by defining STEP_CTRL_STEP_COUNT_EN.
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_IDLE       | key released and stable, waiting for a low level
// ST_PRESS_WAIT | key low, counting stable cycles before accepting press
// ST_HELD       | press accepted, Pressed=1
// ST_REL_WAIT   | key high, counting stable cycles before accepting release
module step_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned RUN_DIV    = 25000000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        KeyN,
    input  logic        FreeRun,
    input  logic        Done,
`ifdef STEP_CTRL_STEP_COUNT_EN
    output logic [15:0] StepCount,
`endif
    output logic        Step,
    output logic        Pressed,
    output logic        Halted
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_DIV - 1);

    logic             ks_meta_q, ks_q;
    logic             fr_meta_q, fr_q, fr_prev_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             press_q, press_d;
    logic             halted_q, halted_d;
    logic             fr_chg;
    logic             run_step;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            ks_meta_q <= 1'b1;
            ks_q      <= 1'b1;
            fr_meta_q <= 1'b0;
            fr_q      <= 1'b0;
            fr_prev_q <= 1'b0;
            state_q   <= ST_IDLE;
            deb_q     <= '0;
            div_q     <= '0;
            press_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            ks_meta_q <= KeyN;
            ks_q      <= ks_meta_q;
            fr_meta_q <= FreeRun;
            fr_q      <= fr_meta_q;
            fr_prev_q <= fr_q;
            state_q   <= state_d;
            deb_q     <= deb_d;
            div_q     <= div_d;
            press_q   <= press_d;
            halted_q  <= halted_d;
        end
    end

    // Debounce FSM; press_d fires on the single transition into HELD.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        press_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ks_q) begin
                    state_d = ST_PRESS_WAIT;
                    deb_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (ks_q) begin
                    state_d = ST_IDLE;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                end else begin
                    deb_d = deb_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (ks_q) begin
                    state_d = ST_REL_WAIT;
                    deb_d   = '0;
                end
            end
            ST_REL_WAIT: begin
                if (!ks_q) begin
                    state_d = ST_HELD;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    deb_d = deb_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                deb_d   = '0;
            end
        endcase
    end

    // A mode change restarts the divider so the first free-run Step is a full period away.
    always_comb begin
        fr_chg   = fr_q ^ fr_prev_q;
        run_step = fr_q && !halted_q && (div_q == RUN_LAST);

        div_d = div_q;
        if (fr_chg || !fr_q) begin
            div_d = '0;
        end else if (!halted_q) begin
            div_d = (div_q == RUN_LAST) ? '0 : div_q + CNT_W'(1);
        end

        halted_d = halted_q;
        if (fr_chg) begin
            halted_d = 1'b0;
        end else if (run_step && Done) begin
            halted_d = 1'b1;
        end else if (press_q) begin
            halted_d = 1'b0;
        end
    end

    assign Step    = fr_q ? run_step : press_q;
    assign Pressed = (state_q == ST_HELD) || (state_q == ST_REL_WAIT);
    assign Halted  = halted_q;

`ifdef STEP_CTRL_STEP_COUNT_EN
    logic [15:0] step_cnt_q;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            step_cnt_q <= '0;
        end else if (Step) begin
            step_cnt_q <= step_cnt_q + 16'd1;
        end
    end

    assign StepCount = step_cnt_q;
`endif

endmodule
